// File: rtl/cci_mpf_shim_rd_credit_if.sv
// Request channel between an AFU-side producer and a MUX-side consumer:
// valid/header/length flow downstream, almost-full flows back upstream.
interface cci_mpf_shim_rd_credit_if #(
    parameter int HDR_WIDTH = 96
);
    logic                 c0_valid;
    logic [HDR_WIDTH-1:0] c0_hdr;
    logic [1:0]           c0_cl_len;
    logic                 c0_alm_full;

    modport master (
        output c0_valid,
        output c0_hdr,
        output c0_cl_len,
        input  c0_alm_full
    );

    modport slave (
        input  c0_valid,
        input  c0_hdr,
        input  c0_cl_len,
        output c0_alm_full
    );
endinterface

// File: rtl/cci_mpf_shim_rd_credit.sv
// Per-port read-line credit throttle: skid FIFO in front of a credit-gated output register.
// Optional stall statistics are enabled with the CCI_MPF_RD_CREDIT_STATS_EN macro.
module cci_mpf_shim_rd_credit #(
    parameter int MAX_LINES          = 64,
    parameter int HDR_WIDTH          = 96,
    parameter int SKID_DEPTH         = 8,
    parameter int ALM_FULL_THRESHOLD = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    cci_mpf_shim_rd_credit_if.slave        afu,
    cci_mpf_shim_rd_credit_if.master       mux,
    input  logic                           rsp_valid,
    input  logic                           rsp_is_rd_line,
    output logic [$clog2(MAX_LINES+1)-1:0] credits_avail,
    output logic [31:0]                    stat_stall_cycles
);
    localparam int PTR_W  = $clog2(SKID_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = $clog2(MAX_LINES + 1);

    logic [HDR_WIDTH+1:0] fifo_mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CRED_W-1:0]    credits_q, credits_d;
    logic                 alm_full_q, alm_full_d;
    logic                 mux_valid_q, mux_valid_d;
    logic [HDR_WIDTH-1:0] mux_hdr_q, mux_hdr_d;
    logic [1:0]           mux_len_q, mux_len_d;

    logic                 fifo_empty, fifo_full;
    logic                 push, fwd, rsp_ret;
    logic [HDR_WIDTH-1:0] head_hdr;
    logic [1:0]           head_len;
    logic [CRED_W:0]      credits_eff, need_lines, credits_net;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(SKID_DEPTH));
    assign push       = afu.c0_valid && !fifo_full;
    assign rsp_ret    = rsp_valid && rsp_is_rd_line;
    assign head_hdr   = fifo_mem_q[rd_ptr_q][HDR_WIDTH+1:2];
    assign head_len   = fifo_mem_q[rd_ptr_q][1:0];

    // A line returned this cycle is already spendable, so the check uses the post-return count.
    always_comb begin
        credits_eff = {1'b0, credits_q} + (CRED_W+1)'(rsp_ret);
        if (credits_eff > (CRED_W+1)'(MAX_LINES)) begin
            credits_eff = (CRED_W+1)'(MAX_LINES);
        end
        need_lines  = (CRED_W+1)'(head_len) + (CRED_W+1)'(1);
        fwd         = !fifo_empty && !mux.c0_alm_full && (credits_eff >= need_lines);
        credits_net = fwd ? (credits_eff - need_lines) : credits_eff;
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = fwd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(fwd);
        alm_full_d  = (count_d >= CNT_W'(SKID_DEPTH - ALM_FULL_THRESHOLD));
        credits_d   = credits_net[CRED_W-1:0];
        mux_valid_d = fwd;
        mux_hdr_d   = head_hdr;
        mux_len_d   = head_len;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {afu.c0_hdr, afu.c0_cl_len};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            credits_q   <= CRED_W'(MAX_LINES);
            alm_full_q  <= 1'b0;
            mux_valid_q <= 1'b0;
            mux_hdr_q   <= '0;
            mux_len_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            credits_q   <= credits_d;
            alm_full_q  <= alm_full_d;
            mux_valid_q <= mux_valid_d;
            mux_hdr_q   <= mux_hdr_d;
            mux_len_q   <= mux_len_d;
        end
    end

    assign afu.c0_alm_full = alm_full_q;
    assign mux.c0_valid    = mux_valid_q;
    assign mux.c0_hdr      = mux_hdr_q;
    assign mux.c0_cl_len   = mux_len_q;
    assign credits_avail   = credits_q;

`ifdef CCI_MPF_RD_CREDIT_STATS_EN
    logic        stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counts only credit starvation; MUX backpressure is not this shim's doing.
    always_comb begin
        stall       = !fifo_empty && !mux.c0_alm_full && !fwd;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stat_stall_cycles = stall_cnt_q;
`else
    assign stat_stall_cycles = '0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(afu.c0_valid && fifo_full))
                else $fatal(1, "cci_mpf_shim_rd_credit: enqueue while skid FIFO full");
            assert (!(rsp_ret && (credits_q == CRED_W'(MAX_LINES))))
                else $fatal(1, "cci_mpf_shim_rd_credit: credit return with no lines outstanding");
        end
    end
`endif
endmodule

// File: doc/cci_mpf_shim_rd_credit.md
Name: cci_mpf_shim_rd_credit

Overview:
- Per-port read-request throttle placed directly upstream of each AFU port of the two-port request MUX.
- Limits outstanding c0 read lines per AFU, so one client cannot monopolise shared FIU read buffering.
- Accepts AFU requests under almost-full protocol into a skid FIFO, then forwards them to the MUX port only when enough line credits exist.
- Credits return one per read-response line routed back to this port.

Parameters:
- MAX_LINES, 64, maximum outstanding read lines (credits at reset).
- HDR_WIDTH, 96, opaque request header bits passed through unchanged.
- SKID_DEPTH, 8, request FIFO entries; power of 2, ≥4.
- ALM_FULL_THRESHOLD, 4, requests the AFU may still issue after afu_c0_alm_full asserts; < SKID_DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- afu_c0_valid  in  1  AFU read request valid
- afu_c0_hdr  in  HDR_WIDTH  request header
- afu_c0_cl_len  in  2  lines minus one (0..3 → 1..4 lines)
- afu_c0_alm_full  out  1  almost-full toward AFU
- mux_c0_valid  out  1  request to MUX port
- mux_c0_hdr  out  HDR_WIDTH  forwarded header
- mux_c0_cl_len  out  2  forwarded length
- mux_c0_alm_full  in  1  MUX-port almost-full; forward nothing while high
- rsp_valid  in  1  c0 response valid for this port (post-MUX routing)
- rsp_is_rd_line  in  1  response is a read-data line (not UMsg/other)
- credits_avail  out  $clog2(MAX_LINES+1)  current credit count
- stat_stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset, synchronous: credits = MAX_LINES, FIFO empty, mux_c0_valid = 0, afu_c0_alm_full = 0, stat_stall_cycles = 0. Reset mid-operation discards queued requests; later responses to pre-reset requests are not supported.
- Enqueue: every cycle afu_c0_valid = 1 pushes {hdr, cl_len}. No backpressure beyond almost-full.
- afu_c0_alm_full = (fifo_count ≥ SKID_DEPTH − ALM_FULL_THRESHOLD), registered from the count after this cycle's enq/deq.
- Enqueue while FIFO full is a protocol error: simulation $fatal; the entry is dropped.
- Forward condition (FWD): FIFO non-empty && !mux_c0_alm_full && credits ≥ head.cl_len + 1.
- Output register: mux_c0_valid/hdr/cl_len loaded each cycle. When FWD, the head is dequeued and valid = 1 on the next cycle; otherwise valid = 0 next cycle. Minimum latency AFU request → mux_c0_valid is 2 cycles (FIFO write, then output register).
- Strictly in-order: a head blocked on credits blocks younger requests, with no bypass.
- Credit update each cycle: credits_next = credits − (FWD ? cl_len+1 : 0) + (rsp_valid && rsp_is_rd_line ? 1 : 0). Simultaneous consume and return are applied net in the same cycle.
- A return when credits == MAX_LINES is an error: simulation $fatal; synthesis saturates at MAX_LINES.
- Credits never go negative, guaranteed by the FWD check.
- A 4-line request with credits = 3 stalls until one line returns. It may then forward in the same cycle the return is observed, because the check uses credits + return-this-cycle.
- credits_avail is the registered credit count.
- Pointer wrap: FIFO pointers are log2(SKID_DEPTH) bits and wrap naturally; the count is tracked separately, with width log2(SKID_DEPTH)+1.

Optional Feature:
- Macro CCI_MPF_RD_CREDIT_STATS_EN.
- When defined: stat_stall_cycles increments (saturating at 2^32−1) every cycle the FIFO is non-empty, mux_c0_alm_full = 0, and FWD = 0 (credit starvation). It clears on reset.
- When undefined: stat_stall_cycles tied to 0 and the counter logic is absent.

Test Plan:
- Reset, then one 1-line request at cycle 0 → mux_c0_valid at cycle 2; credits 64→63. One rsp line → credits 64.
- MAX_LINES=8: issue two 4-line requests → both forward, credits 0. Third 1-line request → held, mux_c0_valid = 0. Single rsp_valid line → forwards that same cycle; credits = 0 after the net update.
- Burst of 4 back-to-back requests with mux_c0_alm_full = 1 → count reaches 4, afu_c0_alm_full = 1 next cycle. Drop mux_c0_alm_full → 4 requests emerge in order on consecutive cycles; afu_c0_alm_full deasserts.
- Credits 5, 4-line request forwarded in the same cycle as a returned line → credits 5−4+1 = 2.
- Extra response with credits = MAX_LINES → $fatal fires; credits remain 64.
- Stats build: MAX_LINES=4, queued 4-line request with credits 0 for 10 cycles → stat_stall_cycles = 10. Non-stats build → stat_stall_cycles stays 0.
